// File: rtl/copperv_lsu_pkg.sv
// copperv_lsu_pkg: shared types for the copperv load/store unit.
//   mem_width_e       - access size encoding (byte .. dword)
//   lsu_state_e       - LSU control FSM states
//   lsu_err_e         - cause reported alongside err
//   data_write_resp_e - write response encoding on the data write bus
package copperv_lsu_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE  = 2'd0,
      MEM_HWORD = 2'd1,
      MEM_WORD  = 2'd2,
      MEM_DWORD = 2'd3
   } mem_width_e;

   typedef enum logic [2:0] {
      LSU_IDLE    = 3'd0,
      LSU_CHECK   = 3'd1,
      LSU_RD_ADDR = 3'd2,
      LSU_RD_DATA = 3'd3,
      LSU_WR_REQ  = 3'd4,
      LSU_WR_RESP = 3'd5,
      LSU_DONE    = 3'd6
   } lsu_state_e;

   typedef enum logic [1:0] {
      LSU_ERR_MISALIGNED    = 2'd0,
      LSU_ERR_ILLEGAL_WIDTH = 2'd1,
      LSU_ERR_BUS_FAIL      = 2'd2,
      LSU_ERR_TIMEOUT       = 2'd3
   } lsu_err_e;

   typedef enum logic {
      DATA_WRITE_RESP_FAIL = 1'b0,
      DATA_WRITE_RESP_OK   = 1'b1
   } data_write_resp_e;

   // Number of bytes touched by an access of the given width (1, 2, 4 or 8).
   function automatic logic [3:0] width_bytes(input mem_width_e w);
      return 4'd1 << w;
   endfunction

endpackage

// File: rtl/copperv_lsu_align.sv
// copperv_lsu_align: purely combinational lane logic for the LSU.
//   lane_i       - byte offset of the access inside the bus word
//   width_i      - access size
//   is_unsigned_i- zero-extend (1) or sign-extend (0) load data
//   wdata_i      - right-aligned store data
//   rd_bus_i     - raw read data bus word
//   wr_data_o    - store data shifted into its byte lanes
//   wr_strobe_o  - byte enables for the store
//   rd_ext_o     - load data extracted from its lanes and extended to XLEN
module copperv_lsu_align
   import copperv_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] lane_i,
   input  mem_width_e                width_i,
   input  logic                      is_unsigned_i,
   input  logic [XLEN-1:0]           wdata_i,
   input  logic [XLEN-1:0]           rd_bus_i,
   output logic [XLEN-1:0]           wr_data_o,
   output logic [XLEN/8-1:0]         wr_strobe_o,
   output logic [XLEN-1:0]           rd_ext_o
);

   localparam int         STRB_W    = XLEN / 8;
   localparam logic [6:0] XLEN_BITS = 7'(XLEN);

   logic [5:0]      bit_shift;
   logic [7:0]      size_ones;
   logic [6:0]      nbits;
   logic [6:0]      drop;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] left;

   assign bit_shift = 6'({lane_i, 3'b000});
   assign wr_data_o = wdata_i << bit_shift;

   always_comb begin
      size_ones = 8'hFF;
      case (width_i)
         MEM_BYTE:  size_ones = 8'h01;
         MEM_HWORD: size_ones = 8'h03;
         MEM_WORD:  size_ones = 8'h0F;
         default:   size_ones = 8'hFF;
      endcase
   end

   assign wr_strobe_o = STRB_W'(size_ones << lane_i);

   // Extension trick: push the selected field to the top of the word, then
   // shift it back down either logically or arithmetically. Accesses as wide
   // as the bus need no extension (drop = 0).
   always_comb begin
      shifted  = rd_bus_i >> bit_shift;
      nbits    = 7'd8 << width_i;
      drop     = (nbits >= XLEN_BITS) ? 7'd0 : (XLEN_BITS - nbits);
      left     = shifted << drop;
      rd_ext_o = is_unsigned_i ? (left >> drop) : XLEN'($signed(left) >>> drop);
   end

endmodule

// File: rtl/copperv_lsu.sv
// copperv_lsu: load/store unit between the control unit and the data buses.
//   clk, rst (async, active low)
//   start/is_store/width/is_unsigned/addr/wdata - request, sampled in IDLE
//   busy/done/rdata/err/err_cause               - status and result
//   dr_addr_*, dr_data_*                        - read address / data channels
//   dw_*, dw_resp_*                             - write request / response channels
module copperv_lsu
   import copperv_lsu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [1:0]            width,
   input  logic                  is_unsigned,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [XLEN-1:0]       wdata,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       rdata,
   output logic                  err,
   output logic [1:0]            err_cause,
   output logic                  dr_addr_valid,
   input  logic                  dr_addr_ready,
   output logic [ADDR_WIDTH-1:0] dr_addr,
   input  logic                  dr_data_valid,
   output logic                  dr_data_ready,
   input  logic [XLEN-1:0]       dr_data,
   output logic                  dw_valid,
   input  logic                  dw_ready,
   output logic [ADDR_WIDTH-1:0] dw_addr,
   output logic [XLEN-1:0]       dw_data,
   output logic [XLEN/8-1:0]     dw_strobe,
   input  logic                  dw_resp_valid,
   output logic                  dw_resp_ready,
   input  logic                  dw_resp
);

   localparam int STRB_W = XLEN / 8;
   localparam int LANE_W = $clog2(STRB_W);
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]      TMO_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_W - 1);

   lsu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   mem_width_e            width_q, width_d;
   logic                  is_store_q, is_store_d;
   logic                  is_unsigned_q, is_unsigned_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;
   logic                  err_q, err_d;
   lsu_err_e              err_cause_q, err_cause_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] dr_addr_q, dr_addr_d;
   logic [ADDR_WIDTH-1:0] dw_addr_q, dw_addr_d;
   logic [XLEN-1:0]       dw_data_q, dw_data_d;
   logic [STRB_W-1:0]     dw_strobe_q, dw_strobe_d;

   logic [XLEN-1:0]   wr_data;
   logic [STRB_W-1:0] wr_strobe;
   logic [XLEN-1:0]   rd_ext;
   logic [3:0]        align_mask;
   logic              illegal_width;
   logic              misaligned;
   logic              timed_out;

   copperv_lsu_align #(.XLEN(XLEN)) u_align (
      .lane_i        (addr_q[LANE_W-1:0]),
      .width_i       (width_q),
      .is_unsigned_i (is_unsigned_q),
      .wdata_i       (wdata_q),
      .rd_bus_i      (dr_data),
      .wr_data_o     (wr_data),
      .wr_strobe_o   (wr_strobe),
      .rd_ext_o      (rd_ext)
   );

   assign align_mask    = width_bytes(width_q) - 4'd1;
   assign illegal_width = (XLEN == 32) && (width_q == MEM_DWORD);
   assign misaligned    = |(addr_q[2:0] & align_mask[2:0]);
   assign timed_out     = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      width_d       = width_q;
      is_store_d    = is_store_q;
      is_unsigned_d = is_unsigned_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      err_cause_d   = err_cause_q;
      cnt_d         = cnt_q;
      dr_addr_d     = dr_addr_q;
      dw_addr_d     = dw_addr_q;
      dw_data_d     = dw_data_q;
      dw_strobe_d   = dw_strobe_q;
      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               addr_d        = addr;
               width_d       = mem_width_e'(width);
               is_store_d    = is_store;
               is_unsigned_d = is_unsigned;
               wdata_d       = wdata;
               err_d         = 1'b0;
               state_d       = LSU_CHECK;
            end
         end
         LSU_CHECK: begin
            if (illegal_width) begin
               err_d       = 1'b1;
               err_cause_d = LSU_ERR_ILLEGAL_WIDTH;
               state_d     = LSU_DONE;
            end else if (misaligned) begin
               err_d       = 1'b1;
               err_cause_d = LSU_ERR_MISALIGNED;
               state_d     = LSU_DONE;
            end else if (is_store_q) begin
               // Payload is registered here so it is stable for the whole
               // time dw_valid is held.
               dw_addr_d   = addr_q & ~LANE_MASK;
               dw_data_d   = wr_data;
               dw_strobe_d = wr_strobe;
               state_d     = LSU_WR_REQ;
            end else begin
               dr_addr_d = addr_q & ~LANE_MASK;
               state_d   = LSU_RD_ADDR;
            end
         end
         LSU_RD_ADDR: begin
            if (dr_addr_ready) begin
               cnt_d   = '0;
               state_d = LSU_RD_DATA;
            end
         end
         LSU_RD_DATA: begin
            if (dr_data_valid) begin
               rdata_d = rd_ext;
               state_d = LSU_DONE;
            end else if (timed_out) begin
               err_d       = 1'b1;
               err_cause_d = LSU_ERR_TIMEOUT;
               state_d     = LSU_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LSU_WR_REQ: begin
            if (dw_ready) begin
               cnt_d   = '0;
               state_d = LSU_WR_RESP;
            end
         end
         LSU_WR_RESP: begin
            if (dw_resp_valid) begin
               if (dw_resp == DATA_WRITE_RESP_FAIL) begin
                  err_d       = 1'b1;
                  err_cause_d = LSU_ERR_BUS_FAIL;
               end
               state_d = LSU_DONE;
            end else if (timed_out) begin
               err_d       = 1'b1;
               err_cause_d = LSU_ERR_TIMEOUT;
               state_d     = LSU_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= LSU_IDLE;
         addr_q        <= '0;
         width_q       <= MEM_BYTE;
         is_store_q    <= 1'b0;
         is_unsigned_q <= 1'b0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         err_cause_q   <= LSU_ERR_MISALIGNED;
         cnt_q         <= '0;
         dr_addr_q     <= '0;
         dw_addr_q     <= '0;
         dw_data_q     <= '0;
         dw_strobe_q   <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         width_q       <= width_d;
         is_store_q    <= is_store_d;
         is_unsigned_q <= is_unsigned_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
         err_cause_q   <= err_cause_d;
         cnt_q         <= cnt_d;
         dr_addr_q     <= dr_addr_d;
         dw_addr_q     <= dw_addr_d;
         dw_data_q     <= dw_data_d;
         dw_strobe_q   <= dw_strobe_d;
      end
   end

   // All handshake outputs decode straight from the state register, so no
   // ready input ever reaches a valid output combinationally.
   assign busy          = (state_q != LSU_IDLE);
   assign done          = (state_q == LSU_DONE);
   assign err           = done && err_q;
   assign err_cause     = err_cause_q;
   assign rdata         = rdata_q;
   assign dr_addr_valid = (state_q == LSU_RD_ADDR);
   assign dr_data_ready = (state_q == LSU_RD_DATA);
   assign dr_addr       = dr_addr_q;
   assign dw_valid      = (state_q == LSU_WR_REQ);
   assign dw_resp_ready = (state_q == LSU_WR_RESP);
   assign dw_addr       = dw_addr_q;
   assign dw_data       = dw_data_q;
   assign dw_strobe     = dw_strobe_q;

endmodule

// File: tb/tb_copperv_lsu.sv
// Bench for copperv_lsu: one XLEN=32 and one XLEN=64 instance (both with a
// 4-cycle timeout) share stimulus; a select bit routes start and the observed
// outputs. Expected results are queued before each request and popped at done.
module tb_copperv_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, is_store = 1'b0, is_unsigned = 1'b0, use64 = 1'b0;
   logic [1:0]  width = 2'd0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0, dr_data = '0;
   logic        dr_addr_ready = 1'b1, dr_data_valid = 1'b1;
   logic        dw_ready = 1'b1, dw_resp_valid = 1'b1, dw_resp = 1'b1;

   always #5 clk = ~clk;

   logic        busy32, done32, err32, dav32, ddr32, dwv32, drr32;
   logic [1:0]  ec32;
   logic [31:0] rdata32, dra32, dwa32, dwd32;
   logic [3:0]  strb32;
   logic        busy64, done64, err64, dav64, ddr64, dwv64, drr64;
   logic [1:0]  ec64;
   logic [63:0] rdata64, dwd64;
   logic [31:0] dra64, dwa64;
   logic [7:0]  strb64;

   copperv_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
      .clk(clk), .rst(rst), .start(start & ~use64), .is_store(is_store), .width(width),
      .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata[31:0]),
      .busy(busy32), .done(done32), .rdata(rdata32), .err(err32), .err_cause(ec32),
      .dr_addr_valid(dav32), .dr_addr_ready(dr_addr_ready), .dr_addr(dra32),
      .dr_data_valid(dr_data_valid), .dr_data_ready(ddr32), .dr_data(dr_data[31:0]),
      .dw_valid(dwv32), .dw_ready(dw_ready), .dw_addr(dwa32), .dw_data(dwd32),
      .dw_strobe(strb32), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(drr32),
      .dw_resp(dw_resp)
   );

   copperv_lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut64 (
      .clk(clk), .rst(rst), .start(start & use64), .is_store(is_store), .width(width),
      .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
      .busy(busy64), .done(done64), .rdata(rdata64), .err(err64), .err_cause(ec64),
      .dr_addr_valid(dav64), .dr_addr_ready(dr_addr_ready), .dr_addr(dra64),
      .dr_data_valid(dr_data_valid), .dr_data_ready(ddr64), .dr_data(dr_data),
      .dw_valid(dwv64), .dw_ready(dw_ready), .dw_addr(dwa64), .dw_data(dwd64),
      .dw_strobe(strb64), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(drr64),
      .dw_resp(dw_resp)
   );

   logic        m_busy, m_done, m_err, m_dav, m_dwv;
   logic [1:0]  m_ec;
   logic [63:0] m_rdata, m_dwd;
   logic [31:0] m_dra, m_dwa;
   logic [7:0]  m_strb;

   always_comb begin
      if (use64) begin
         m_busy = busy64; m_done = done64; m_err = err64; m_dav = dav64; m_dwv = dwv64;
         m_ec = ec64; m_rdata = rdata64; m_dwd = dwd64; m_dra = dra64; m_dwa = dwa64;
         m_strb = strb64;
      end else begin
         m_busy = busy32; m_done = done32; m_err = err32; m_dav = dav32; m_dwv = dwv32;
         m_ec = ec32; m_rdata = {32'd0, rdata32}; m_dwd = {32'd0, dwd32}; m_dra = dra32;
         m_dwa = dwa32; m_strb = {4'd0, strb32};
      end
   end

   typedef struct {
      string       tag;
      logic [63:0] rdata;
      logic        err;
      logic [1:0]  cause;
      int          lat;
      logic [31:0] baddr;
      logic [63:0] bdata;
      logic [7:0]  bstrb;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void expect_push(input string tag, input logic [63:0] rd, input logic e,
                                       input logic [1:0] ec, input int lat, input logic [31:0] ba,
                                       input logic [63:0] bd, input logic [7:0] bs);
      exp_t x;
      x.tag = tag; x.rdata = rd; x.err = e; x.cause = ec; x.lat = lat;
      x.baddr = ba; x.bdata = bd; x.bstrb = bs;
      sb.push_back(x);
   endfunction

   // Issue one request and follow it to done (bounded), then check against
   // the oldest scoreboard entry.
   task automatic go(input logic sel, input logic st, input logic [1:0] w, input logic uns,
                     input logic [31:0] a, input logic [63:0] wd);
      exp_t        e;
      int          lat;
      logic        seen_done, seen_bus, busy_c1, got_err;
      logic [1:0]  got_ec;
      logic [31:0] bus_a;
      logic [63:0] bus_d, got_rd;
      logic [7:0]  bus_s;
      @(negedge clk);
      use64 = sel; start = 1'b1; is_store = st; width = w; is_unsigned = uns;
      addr = a; wdata = wd;
      lat = 0; seen_done = 1'b0; seen_bus = 1'b0; busy_c1 = 1'b0; got_err = 1'b0;
      got_ec = '0; bus_a = '0; bus_d = '0; bus_s = '0; got_rd = '0;
      while (!seen_done && lat < 40) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 1) busy_c1 = m_busy;
         if ((m_dav || m_dwv) && !seen_bus) begin
            seen_bus = 1'b1;
            bus_a = m_dav ? m_dra : m_dwa;
            bus_d = m_dwd;
            bus_s = m_strb;
         end
         if (m_done) begin
            seen_done = 1'b1;
            got_rd = m_rdata; got_err = m_err; got_ec = m_ec;
         end
      end
      e = sb.pop_front();
      $display("txn %s: x64=%0d store=%0d addr=%h lat=%0d err=%0d cause=%0d rdata=%h bus=%0d/%h/%h/%h",
               e.tag, sel, st, a, lat, got_err, got_ec, got_rd, seen_bus, bus_a, bus_d, bus_s);
      chk({e.tag, "/done"}, 64'(seen_done), 64'd1);
      chk({e.tag, "/lat"}, 64'(lat), 64'(e.lat));
      chk({e.tag, "/busy"}, 64'(busy_c1), 64'd1);
      chk({e.tag, "/err"}, 64'(got_err), 64'(e.err));
      if (e.err) begin
         chk({e.tag, "/cause"}, 64'(got_ec), 64'(e.cause));
         if (e.cause != 2'd2 && e.cause != 2'd3)
            chk({e.tag, "/no_bus"}, 64'(seen_bus), 64'd0);
      end else begin
         chk({e.tag, "/bus_addr"}, 64'(bus_a), 64'(e.baddr));
         if (st) begin
            chk({e.tag, "/dw_data"}, bus_d, e.bdata);
            chk({e.tag, "/dw_strobe"}, 64'(bus_s), 64'(e.bstrb));
         end else begin
            chk({e.tag, "/rdata"}, got_rd, e.rdata);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done_seen;
      // Reset state
      @(negedge clk);
      chk("reset/busy", 64'(busy32 | busy64), 64'd0);
      chk("reset/done", 64'(done32 | done64), 64'd0);
      chk("reset/valids", 64'({dav32, ddr32, dwv32, drr32, dav64, ddr64, dwv64, drr64}), 64'd0);
      chk("reset/data32", {rdata32, dwd32}, 64'd0);
      chk("reset/addr32", {dra32, dwa32}, 64'd0);
      chk("reset/misc", 64'({err32, ec32, strb32, err64, ec64, strb64}), 64'd0);
      rst = 1'b1;

      // Byte loads from lane 3, signed then unsigned
      dr_data = 64'h0000_0000_80AA_BBCC;
      expect_push("lb_s", 64'hFFFF_FF80, 0, 0, 4, 32'h100, 0, 0);
      go(0, 0, 2'd0, 0, 32'h103, 0);
      expect_push("lb_u", 64'h0000_0080, 0, 0, 4, 32'h100, 0, 0);
      go(0, 0, 2'd0, 1, 32'h103, 0);

      // Halfword store into upper lanes
      dw_resp = 1'b1;
      expect_push("sh", 0, 0, 0, 4, 32'h200, 64'h1234_0000, 8'h0C);
      go(0, 1, 2'd1, 0, 32'h202, 64'h1234);

      // Misaligned word load: no bus traffic, done two cycles after start
      expect_push("lw_mis", 0, 1, 2'd0, 2, 0, 0, 0);
      go(0, 0, 2'd2, 0, 32'h101, 0);

      // Dword load: legal at XLEN=64, illegal width at XLEN=32
      dr_data = 64'h0123_4567_89AB_CDEF;
      expect_push("ld64", 64'h0123_4567_89AB_CDEF, 0, 0, 4, 32'h8, 0, 0);
      go(1, 0, 2'd3, 0, 32'h8, 0);
      expect_push("ld32", 0, 1, 2'd1, 2, 0, 0, 0);
      go(0, 0, 2'd3, 0, 32'h8, 0);

      // XLEN=64 sub-word lanes
      dr_data = 64'hF123_4567_89AB_CDEF;
      expect_push("lw64_s", 64'hFFFF_FFFF_F123_4567, 0, 0, 4, 32'h8, 0, 0);
      go(1, 0, 2'd2, 0, 32'hC, 0);
      expect_push("lb64_u", 64'h0000_0000_0000_0045, 0, 0, 4, 32'h8, 0, 0);
      go(1, 0, 2'd0, 1, 32'hD, 0);
      expect_push("sb64", 0, 0, 0, 4, 32'h0, 64'hAB00_0000_0000_0000, 8'h80);
      go(1, 1, 2'd0, 0, 32'h7, 64'hAB);

      // Write response failure
      dw_resp = 1'b0;
      expect_push("sw_fail", 0, 1, 2'd2, 4, 0, 0, 0);
      go(0, 1, 2'd2, 0, 32'h300, 64'hDEAD_BEEF);
      dw_resp = 1'b1;

      // Read data never arrives: timeout after 4 waiting cycles
      dr_data_valid = 1'b0;
      expect_push("lw_tmo", 0, 1, 2'd3, 7, 0, 0, 0);
      go(0, 0, 2'd2, 0, 32'h40, 0);
      dr_data_valid = 1'b1;

      // Normal loads afterwards
      dr_data = 64'h0000_0000_BEEF_1234;
      expect_push("lhu", 64'h0000_BEEF, 0, 0, 4, 32'h0, 0, 0);
      go(0, 0, 2'd1, 1, 32'h2, 0);
      expect_push("lh_s", 64'hFFFF_BEEF, 0, 0, 4, 32'h0, 0, 0);
      go(0, 0, 2'd1, 0, 32'h2, 0);

      // Reset while waiting in RD_DATA
      dr_data_valid = 1'b0;
      @(negedge clk);
      use64 = 1'b0; start = 1'b1; is_store = 1'b0; width = 2'd2; is_unsigned = 1'b0;
      addr = 32'h44;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid/in_rd_data", 64'(ddr32), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid/ctrl", 64'({busy32, done32, err32, dav32, ddr32, dwv32, drr32}), 64'd0);
      chk("rst_mid/rdata", 64'(rdata32), 64'd0);
      chk("rst_mid/addr", {dra32, dwa32}, 64'd0);
      chk("rst_mid/misc", 64'({ec32, strb32, dwd32}), 64'd0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done32) done_seen = 1'b1;
      end
      chk("rst_mid/no_done", 64'(done_seen), 64'd0);
      rst = 1'b1;
      dr_data_valid = 1'b1;
      dr_data = 64'h0000_0000_CAFE_F00D;
      expect_push("lw_after_rst", 64'hCAFE_F00D, 0, 0, 4, 32'h44, 0, 0);
      go(0, 0, 2'd2, 1, 32'h44, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
